run_end_detector: RTL and testbench
===================================

Name: run_end_detector

Overview:
- Multi-channel, parametrised successor to the single-bit Mealy zero detector.
- Each channel counts the current run of a programmable "run symbol" on its serial input.
- Each channel flags, Mealy-style in the same cycle, the first opposite symbol that ends a run of at least min_run symbols.
- Also captures the length of every detected run. Sits beside serial line receivers for framing and idle detection.

Parameters:
- CH, 4, number of independent serial channels.
- CW, 4, run-counter width per channel; counters saturate at 2^CW-1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- en  input  1  global enable; low holds all counters and forces y_out to 0.
- pol  input  1  run symbol: 1 detects 0-after-ones, 0 detects 1-after-zeros.
- min_run  input  CW  minimum run length needed for detection; value 0 is treated as 1.
- x_in  input  CH  serial data, bit i belongs to channel i.
- y_out  output  CH  detection flag per channel.
- last_len  output  CH*CW  length of the most recent detected run; channel i occupies bits [i*CW +: CW].
- det_any  output  1  OR of y_out.

Behaviour:
- Reset: run_cnt[i]=0, last_len=0, pol_q=0. Outputs y_out=0 and det_any=0 while rstn is low. Reset acts asynchronously mid-run: counters clear immediately and no detection occurs until runs rebuild after release.
- pol_q is a register holding pol from the previous cycle.
- Effective threshold: thr = (min_run==0) ? 1 : min_run, unsigned compare.
- Counter update, per channel, on clk with en=1:
  - If pol != pol_q: run_cnt <= 0 for all channels. This has priority; no detection in that cycle.
  - Else if x_in[i]==pol: run_cnt <= run_cnt+1, saturating at 2^CW-1 (never wraps to 0).
  - Else: run_cnt <= 0.
- Counter update with en=0: run_cnt holds. pol_q still tracks pol.
- Combinational detect (Mealy, zero latency, default build):
  - y_out[i] = en & (pol==pol_q) & (x_in[i]!=pol) & (run_cnt[i] >= thr).
  - Same cycle as the terminating symbol; y_out is a one-cycle pulse because the counter clears on that edge.
- last_len[i] <= run_cnt[i] on the clk edge where y_out[i]=1; otherwise it holds. A saturated run reports 2^CW-1.
- Per-channel states, implied by run_cnt: IDLE (0), BUILDING (1..thr-1), ARMED (>=thr). A terminating symbol in any state returns to IDLE.
- min_run changes take effect in the same cycle, both for comparison and for arming. The counter is not cleared.
- Equivalence: pol=1, min_run=1, CH=1 reproduces the legacy zero-detector output sequence exactly.

Optional Feature:
- Macro: RUN_END_DETECTOR_REG_OUT_EN.
- Defined:
  - y_out and det_any are registered: y_out_q <= detect term, reset 0.
  - Detection appears one cycle after the terminating symbol, as a 1-cycle pulse.
  - last_len update timing is unchanged, so last_len is already valid when y_out_q rises.
  - Glitch-free output for crossing into other logic.
- Undefined: combinational Mealy output as described above.

Test Plan:
- Reset mid-run:
  - Stimulus: CH=1, pol=1, min_run=1; x_in=1,1, assert rstn low, release, then x_in=0.
  - Required: y_out stays 0 throughout; run_cnt is 0 after release.
- Legacy equivalence:
  - Stimulus: pol=1, min_run=1, x_in=0,1,1,0,0,1,0.
  - Required: y_out=0,0,0,1,0,0,1 in the same cycles; last_len=2 after cycle 3, then 1 after cycle 6.
- Threshold:
  - Stimulus: min_run=3; ch0 x=1,1,0; ch1 x=1,1,1,0.
  - Required: ch0 never flags; ch1 flags on its 0, last_len[ch1]=3; det_any=1 only in that cycle.
- Saturation:
  - Stimulus: CW=4, pol=0, 20 zeros then a 1.
  - Required: run_cnt holds at 15 (no wrap); y_out=1 on the 1; last_len=15.
- Polarity switch and enable:
  - Stimulus: after 3 ones, flip pol to 0 with x_in=0.
  - Required: no detection; all counters clear.
  - Stimulus: en=0 for 2 cycles mid-run.
  - Required: counts are held; a 0 during en=0 gives y_out=0; on re-enable, the run resumes from the held count.
- With RUN_END_DETECTOR_REG_OUT_EN:
  - Stimulus: repeat the legacy sequence.
  - Required: y_out=0,0,0,0,1,0,0,1, i.e. each pulse delayed exactly one cycle.

Source files
------------

// File: rtl/run_end_detector.sv
// Per-channel run-length tracker: flags the symbol that ends a run of >= min_run run symbols and captures its length.
// Latency: y_out/det_any are combinational (same cycle as terminating symbol); one cycle later with RUN_END_DETECTOR_REG_OUT_EN.
// Backpressure: none; en=0 freezes counters and suppresses detection while pol_q keeps tracking pol.
module run_end_detector #(
    parameter int CH = 4,
    parameter int CW = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               pol,
    input  logic [CW-1:0]      min_run,
    input  logic [CH-1:0]      x_in,
    output logic [CH-1:0]      y_out,
    output logic [CH*CW-1:0]   last_len,
    output logic               det_any
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          pol_q;
    logic          pol_same;
    logic [CW-1:0] thr;
    logic [CH-1:0] det;

    assign pol_same = (pol == pol_q);
    assign thr      = (min_run == '0) ? CW'(1) : min_run;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pol_q <= 1'b0;
        end else begin
            pol_q <= pol;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CW-1:0] run_cnt;
        logic [CW-1:0] len_q;

        assign det[i] = en & pol_same & (x_in[i] != pol) & (run_cnt >= thr);
        assign last_len[i*CW +: CW] = len_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                run_cnt <= '0;
                len_q   <= '0;
            end else begin
                if (det[i]) begin
                    len_q <= run_cnt;
                end
                if (en) begin
                    // A polarity change invalidates every run in progress.
                    if (!pol_same) begin
                        run_cnt <= '0;
                    end else if (x_in[i] == pol) begin
                        if (run_cnt != CNT_MAX) begin
                            run_cnt <= run_cnt + CW'(1);
                        end
                    end else begin
                        run_cnt <= '0;
                    end
                end
            end
        end
    end

`ifdef RUN_END_DETECTOR_REG_OUT_EN
    logic [CH-1:0] y_out_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_out_q <= '0;
        end else begin
            y_out_q <= det;
        end
    end

    assign y_out   = y_out_q;
    assign det_any = |y_out_q;
`else
    assign y_out   = det;
    assign det_any = |det;
`endif

endmodule

// File: tb/tb_run_end_detector.sv
// Directed bench for run_end_detector (CH=4, CW=4); expected flags follow the registered timing when RUN_END_DETECTOR_REG_OUT_EN is set.
module tb_run_end_detector;

    localparam int CH = 4;
    localparam int CW = 4;

    logic               clk     = 1'b0;
    logic               rstn    = 1'b0;
    logic               en      = 1'b1;
    logic               pol     = 1'b1;
    logic [CW-1:0]      min_run = 4'd1;
    logic [CH-1:0]      x_in    = '0;
    logic [CH-1:0]      y_out;
    logic [CH*CW-1:0]   last_len;
    logic               det_any;

    int n_checks = 0;
    int n_errors = 0;
    logic [CH-1:0] prev_y = '0;

    run_end_detector #(.CH(CH), .CW(CW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .pol      (pol),
        .min_run  (min_run),
        .x_in     (x_in),
        .y_out    (y_out),
        .last_len (last_len),
        .det_any  (det_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one symbol vector, sample flags mid-cycle, then step past the edge.
    task automatic cyc(input logic [CH-1:0] x, input logic [CH-1:0] exp_y, input string tag);
        logic [CH-1:0] want;
        x_in = x;
        @(negedge clk);
`ifdef RUN_END_DETECTOR_REG_OUT_EN
        want = prev_y;
`else
        want = exp_y;
`endif
        prev_y = exp_y;
        check({tag, "_y"}, 32'(y_out), 32'(want));
        check({tag, "_any"}, 32'(det_any), 32'(|want));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit lx [7];
        bit ly [7];
        lx = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ly = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        #1;
        check("reset_y", 32'(y_out), 32'h0);
        check("reset_any", 32'(det_any), 32'h0);
        check("reset_len", 32'(last_len), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(4'b0000, 4'b0000, "settle");

        // Legacy zero-detector sequence on channel 0
        for (int i = 0; i < 7; i++) begin
            cyc({3'b000, lx[i]}, {3'b000, ly[i]}, "legacy");
            if (i == 3) check("legacy_len2", 32'(last_len), 32'h0002);
            if (i == 6) check("legacy_len1", 32'(last_len), 32'h0001);
        end
        cyc(4'b0000, 4'b0000, "legacy_tail");

        // Asynchronous reset in the middle of a run
        cyc(4'b0001, 4'b0000, "rst_run");
        cyc(4'b0001, 4'b0000, "rst_run");
        x_in = 4'b0000;
        rstn = 1'b0;
        #3;
        check("rst_mid_y", 32'(y_out), 32'h0);
        check("rst_mid_any", 32'(det_any), 32'h0);
        check("rst_mid_len", 32'(last_len), 32'h0);
        prev_y = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(4'b0000, 4'b0000, "rst_rel0");
        cyc(4'b0000, 4'b0000, "rst_rel1");

        // Threshold 3: ch0 run of 2 stays quiet, ch1 run of 3 flags
        min_run = 4'd3;
        cyc(4'b0011, 4'b0000, "thr");
        cyc(4'b0011, 4'b0000, "thr");
        cyc(4'b0010, 4'b0000, "thr_ch0_short");
        cyc(4'b0000, 4'b0010, "thr_ch1_hit");
        check("thr_len", 32'(last_len), 32'h0030);
        cyc(4'b0000, 4'b0000, "thr_after");

        // min_run=0 behaves as 1
        min_run = 4'd0;
        cyc(4'b0100, 4'b0000, "min0");
        cyc(4'b0000, 4'b0100, "min0_hit");
        check("min0_len", 32'(last_len), 32'h0130);

        // pol=0: 20 zeros on ch0 saturate at 15, threshold at the maximum
        pol = 1'b0;
        min_run = 4'd15;
        cyc(4'b1111, 4'b0000, "pol0_clr");
        for (int i = 0; i < 20; i++) begin
            cyc(4'b1110, 4'b0000, "sat_run");
        end
        cyc(4'b1111, 4'b0001, "sat_hit");
        check("sat_len", 32'(last_len), 32'h013F);
        cyc(4'b1111, 4'b0000, "sat_after");

        // Polarity flip after three ones clears every counter
        pol = 1'b1;
        min_run = 4'd1;
        cyc(4'b0000, 4'b0000, "pol1_clr");
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0001, 4'b0000, "flip_run");
        end
        pol = 1'b0;
        cyc(4'b0000, 4'b0000, "flip");
        cyc(4'b0001, 4'b0000, "flip_chk");

        // Enable low for two cycles holds counts and masks detection
        cyc(4'b0000, 4'b0000, "en_run");
        en = 1'b0;
        cyc(4'b0001, 4'b0000, "en_off_term");
        cyc(4'b0000, 4'b0000, "en_off_hold");
        min_run = 4'd2;
        en = 1'b1;
        cyc(4'b0000, 4'b0000, "en_resume");
        cyc(4'b1111, 4'b1111, "en_end");
        check("en_len", 32'(last_len), 32'h3332);
        cyc(4'b0000, 4'b0000, "tail");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
